// File: rtl/modulo_counter_if.sv
// -----------------------------------------------------------------------------
// modulo_counter_if
// Groups the counter's enable input and its count/carry outputs so a
// controller can connect to the counter through a single port.
//
// Signals:
//   cnt_en : count enable, driven by the controller (master)
//   out    : current count [WIDTH-1:0], driven by the counter (slave)
//   cout   : terminal-count carry, driven by the counter (slave)
//
// Handshake: none. cnt_en is a level, sampled on every rising clk edge; it may
// change every cycle. out and cout are always valid; there is no ready.
// -----------------------------------------------------------------------------
interface modulo_counter_if #(
  parameter int WIDTH = 8
);
  logic             cnt_en;
  logic [WIDTH-1:0] out;
  logic             cout;

  modport master (
    output cnt_en,
    input  out,
    input  cout
  );

  modport slave (
    input  cnt_en,
    output out,
    output cout
  );
endinterface

// File: rtl/modulo_counter.sv
// -----------------------------------------------------------------------------
// modulo_counter
// Up-counter that advances once per enabled clock edge through 0..MODULO-1 and
// wraps to 0. cout flags the enabled cycle whose closing edge performs the
// wrap, so a downstream counter can advance once per full period.
//
// Parameters:
//   WIDTH  : count width in bits (must match the interface WIDTH)
//   MODULO : number of states, 2 <= MODULO <= 2**WIDTH
//
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset, clears the count immediately
//   bus    : slave side of modulo_counter_if (cnt_en in; out, cout out)
// -----------------------------------------------------------------------------
module modulo_counter #(
  parameter int WIDTH  = 8,
  parameter int MODULO = 150
) (
  input  logic              clk,
  input  logic              rst,
  modulo_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);

  // ">=" rather than "==" so a corrupted value above LAST also returns to 0
  // on the next enabled edge instead of running on to the natural rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (bus.cnt_en) begin
      if (r_count >= LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  assign bus.out  = r_count;
  // Equality keeps cout low while the count is out of range.
  assign bus.cout = w_at_last & bus.cnt_en;

endmodule

// File: tb/tb_modulo_counter.sv
// -----------------------------------------------------------------------------
// tb_modulo_counter
// Self-checking bench for modulo_counter (WIDTH=8, MODULO=150). A reference
// count kept as a plain integer advances by (n+1) % MODULO on every enabled,
// non-reset edge; cout is expected to be (n == MODULO-1) && cnt_en.
// -----------------------------------------------------------------------------
module tb_modulo_counter;

  localparam int WIDTH  = 8;
  localparam int MODULO = 150;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  modulo_counter_if #(.WIDTH(WIDTH)) bus ();

  modulo_counter #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int model    = 0;   // reference count

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"}, 32'(bus.out), 32'(model));
    check({tag, ".cout"}, 32'(bus.cout),
          32'((model == MODULO - 1) && (bus.cnt_en == 1'b1)));
  endtask

  // ---------------------------------------------------------------- driver
  // One rising edge; the model advances first from the inputs that the edge
  // will sample, then outputs are available 1 time unit after the edge.
  task automatic tick();
    if (rst && bus.cnt_en) model = (model + 1) % MODULO;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_pulse(input string tag);
    rst = 1'b0;
    model = 0;
    #1;
    check_outputs(tag);
    #1;
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------- sequence
  initial begin
    rst        = 1'b1;
    bus.cnt_en = 1'b0;

    // Reset asserted between edges with cnt_en high, held for 2 edges.
    #12;
    bus.cnt_en = 1'b1;
    rst        = 1'b0;
    model      = 0;
    #1;
    check_outputs("reset_async");
    for (int i = 0; i < 2; i++) begin
      tick();
      check_outputs("reset_hold");
    end

    // Full period.
    rst = 1'b1;
    for (int i = 0; i < MODULO; i++) begin
      check_outputs("period_pre");
      tick();
      check_outputs("period");
    end
    check("period_end", 32'(bus.out), 32'd0);

    // Continued count.
    for (int i = 0; i < 3; i++) tick();
    check("continue", 32'(bus.out), 32'd3);

    // Enable hold.
    bus.cnt_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outputs("hold");
    end
    check("hold_val", 32'(bus.out), 32'd3);

    // Reset while disabled, no clock edge.
    #2;
    async_reset_pulse("reset_disabled");
    bus.cnt_en = 1'b1;
    tick();
    check("after_release", 32'(bus.out), 32'd1);

    // Enable gating at terminal count.
    while (model != MODULO - 1) tick();
    bus.cnt_en = 1'b0;
    #1;
    check("gate_cout_low", 32'(bus.cout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outputs("gate_hold");
    end
    bus.cnt_en = 1'b1;
    #1;
    check("gate_cout_high", 32'(bus.cout), 32'd1);
    tick();
    check("gate_wrap", 32'(bus.out), 32'd0);

    // Randomized enable with occasional asynchronous resets.
    for (int i = 0; i < 1200; i++) begin
      bus.cnt_en = ($urandom_range(0, 3) != 0);
      #1;
      check_outputs("rand_comb");
      if ($urandom_range(0, 99) == 0) begin
        async_reset_pulse("rand_reset");
      end
      tick();
      check_outputs("rand_edge");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
